// File: rtl/rfm_bank_unit.sv
// -----------------------------------------------------------------------------
// rfm_bank_unit
// Per-bank DRAM Refresh Management (RFM) row-hammer tracker.
//
// A space-saving frequency table follows the most-activated rows of one bank.
// Each ACT bumps the rolling accumulated ACT counter (RAA) and the matching
// row's count. A miss allocates a free slot, or evicts the smallest count when
// the table is full. An RFM is serviced once RAA has reached RFM_TH and at least
// one tracked row has a non-zero count. A serviced RFM emits a single registered
// NRR pulse for the hottest row, zeroes that row's count and subtracts RFM_TH
// from RAA.
//
// Ports:
//   clk       in   clock; all state updates on the rising edge
//   rstn      in   synchronous reset, ACTIVE-HIGH despite its name
//   act_cmd   in   one-cycle ACT strobe
//   act_addr  in   row address of the ACT (sampled when act_cmd=1)
//   rfm_cmd   in   one-cycle RFM strobe
//   nrr_cmd   out  one-cycle NRR request pulse, one clock after a serviced RFM
//   nrr_addr  out  row to refresh; holds its last value between pulses
//
// Optional build macro:
//   RFM_INVALIDATE_EN - a serviced entry is freed (valid=0, count=0, addr=0)
//                       instead of only having its count zeroed.
// -----------------------------------------------------------------------------
module rfm_bank_unit #(
  parameter int NUM_ENTRY      = 64,
  parameter int NUM_ENTRY_BITS = 6,
  parameter int RFM_TH         = 20,
  parameter int ADDR_SIZE      = 18,
  parameter int CNT_SIZE       = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 act_cmd,
  input  logic [ADDR_SIZE-1:0] act_addr,
  input  logic                 rfm_cmd,
  output logic                 nrr_cmd,
  output logic [ADDR_SIZE-1:0] nrr_addr
);

  localparam logic [CNT_SIZE-1:0] CNT_MAX  = {CNT_SIZE{1'b1}};
  localparam logic [CNT_SIZE-1:0] CNT_ZERO = {CNT_SIZE{1'b0}};
  localparam logic [CNT_SIZE-1:0] CNT_ONE  = CNT_SIZE'(1);
  localparam logic [CNT_SIZE-1:0] TH_CNT   = CNT_SIZE'(RFM_TH);

  // Saturating increment shared by the RAA counter and the per-entry counters.
  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    logic [CNT_SIZE-1:0] r;
    if (v == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // Table state and its next-state values
  logic [ADDR_SIZE-1:0] addr_q  [NUM_ENTRY];
  logic [ADDR_SIZE-1:0] addr_d  [NUM_ENTRY];
  logic [CNT_SIZE-1:0]  cnt_q   [NUM_ENTRY];
  logic [CNT_SIZE-1:0]  cnt_d   [NUM_ENTRY];
  logic [NUM_ENTRY-1:0] valid_q;
  logic [NUM_ENTRY-1:0] valid_d;
  logic [CNT_SIZE-1:0]  raa_q;
  logic [CNT_SIZE-1:0]  raa_d;
  logic                 nrr_cmd_q;
  logic                 nrr_cmd_d;
  logic [ADDR_SIZE-1:0] nrr_addr_q;
  logic [ADDR_SIZE-1:0] nrr_addr_d;

  // Search results over the pre-edge table
  logic                      hit_found_s;
  logic [NUM_ENTRY_BITS-1:0] hit_idx_s;
  logic                      free_found_s;
  logic [NUM_ENTRY_BITS-1:0] free_idx_s;
  logic [NUM_ENTRY_BITS-1:0] min_idx_s;
  logic [CNT_SIZE-1:0]       min_cnt_s;
  logic                      max_found_s;
  logic [NUM_ENTRY_BITS-1:0] max_idx_s;
  logic [CNT_SIZE-1:0]       max_cnt_s;
  logic                      rfm_ok_s;
  logic [CNT_SIZE-1:0]       raa_inc_s;

  // Table searches: hit and first free entry (scanned high-to-low so the lowest
  // index is written last), min and max counts (scanned low-to-high with strict
  // compares so ties keep the lowest index).
  always_comb begin
    hit_found_s  = 1'b0;
    hit_idx_s    = {NUM_ENTRY_BITS{1'b0}};
    free_found_s = 1'b0;
    free_idx_s   = {NUM_ENTRY_BITS{1'b0}};
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == act_addr)) begin
        hit_found_s = 1'b1;
        hit_idx_s   = NUM_ENTRY_BITS'(i);
      end else begin
        hit_idx_s   = hit_idx_s;
      end
      if (!valid_q[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = NUM_ENTRY_BITS'(i);
      end else begin
        free_idx_s   = free_idx_s;
      end
    end

    // Only consulted when the table is full, so every entry is valid here.
    // Starting from all-ones means an all-saturated table still picks index 0.
    min_cnt_s = CNT_MAX;
    min_idx_s = {NUM_ENTRY_BITS{1'b0}};
    // Starting from zero means only entries with count > 0 can be selected,
    // so max_found_s doubles as the "something worth refreshing" flag.
    max_found_s = 1'b0;
    max_cnt_s   = CNT_ZERO;
    max_idx_s   = {NUM_ENTRY_BITS{1'b0}};
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (cnt_q[i] < min_cnt_s) begin
        min_cnt_s = cnt_q[i];
        min_idx_s = NUM_ENTRY_BITS'(i);
      end else begin
        min_idx_s = min_idx_s;
      end
      if (valid_q[i] && (cnt_q[i] > max_cnt_s)) begin
        max_found_s = 1'b1;
        max_cnt_s   = cnt_q[i];
        max_idx_s   = NUM_ENTRY_BITS'(i);
      end else begin
        max_idx_s   = max_idx_s;
      end
    end
  end

  // Next-state: the RFM effect is applied first, and the ACT effect is then
  // layered on top of it. Both are computed from the pre-edge table, so an ACT
  // that hits the entry just serviced ends with count 1.
  always_comb begin
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    nrr_cmd_d  = 1'b0;
    nrr_addr_d = nrr_addr_q;

    rfm_ok_s  = rfm_cmd && (raa_q >= TH_CNT) && max_found_s;
    raa_inc_s = act_cmd ? sat_inc(raa_q) : raa_q;

    if (rfm_ok_s) begin
      // raa_inc_s >= raa_q >= RFM_TH, so this subtraction never wraps.
      raa_d              = raa_inc_s - TH_CNT;
      nrr_cmd_d          = 1'b1;
      nrr_addr_d         = addr_q[max_idx_s];
      cnt_d[max_idx_s]   = CNT_ZERO;
`ifdef RFM_INVALIDATE_EN
      valid_d[max_idx_s] = 1'b0;
      addr_d[max_idx_s]  = {ADDR_SIZE{1'b0}};
`endif
    end else begin
      raa_d = raa_inc_s;
    end

    if (act_cmd) begin
      if (hit_found_s) begin
        if (rfm_ok_s && (hit_idx_s == max_idx_s)) begin
          cnt_d[hit_idx_s] = CNT_ONE;
        end else begin
          cnt_d[hit_idx_s] = sat_inc(cnt_q[hit_idx_s]);
        end
        // A same-cycle ACT keeps the row tracked even if it was just serviced.
        valid_d[hit_idx_s] = 1'b1;
        addr_d[hit_idx_s]  = addr_q[hit_idx_s];
      end else if (free_found_s) begin
        valid_d[free_idx_s] = 1'b1;
        addr_d[free_idx_s]  = act_addr;
        cnt_d[free_idx_s]   = CNT_ONE;
      end else begin
        // Space-saving eviction: the new row inherits the old minimum + 1.
        valid_d[min_idx_s] = 1'b1;
        addr_d[min_idx_s]  = act_addr;
        cnt_d[min_idx_s]   = sat_inc(min_cnt_s);
      end
    end else begin
      valid_d = valid_d;
    end
  end

  // State registers with synchronous active-high reset on rstn.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        addr_q[i] <= {ADDR_SIZE{1'b0}};
        cnt_q[i]  <= CNT_ZERO;
      end
      valid_q    <= {NUM_ENTRY{1'b0}};
      raa_q      <= CNT_ZERO;
      nrr_cmd_q  <= 1'b0;
      nrr_addr_q <= {ADDR_SIZE{1'b0}};
    end else begin
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      raa_q      <= raa_d;
      nrr_cmd_q  <= nrr_cmd_d;
      nrr_addr_q <= nrr_addr_d;
    end
  end

  assign nrr_cmd  = nrr_cmd_q;
  assign nrr_addr = nrr_addr_q;

endmodule

// File: tb/tb_rfm_bank_unit.sv
// -----------------------------------------------------------------------------
// tb_rfm_bank_unit
// Scoreboard bench for rfm_bank_unit. Every driven cycle pushes the expected
// {nrr_cmd, nrr_addr} seen one clock later. The expectation comes from a
// behavioural table model that uses plain arrays and arithmetic. A monitor on
// the falling edge pops each entry when it falls due and compares it with the
// DUT outputs.
// -----------------------------------------------------------------------------
module tb_rfm_bank_unit;

  localparam int NE = 64;
  localparam int TH = 20;
  localparam int AW = 18;
  localparam longint unsigned CMAX = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          act_cmd = 1'b0;
  logic [AW-1:0] act_addr = '0;
  logic          rfm_cmd = 1'b0;
  logic          nrr_cmd;
  logic [AW-1:0] nrr_addr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int            due;
    logic          cmd;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  longint unsigned m_cnt  [NE];
  logic [AW-1:0]   m_addr [NE];
  bit              m_valid[NE];
  longint unsigned m_raa;
  logic [AW-1:0]   m_last;

  rfm_bank_unit dut (
    .clk      (clk),
    .rstn     (rstn),
    .act_cmd  (act_cmd),
    .act_addr (act_addr),
    .rfm_cmd  (rfm_cmd),
    .nrr_cmd  (nrr_cmd),
    .nrr_addr (nrr_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint unsigned sat(input longint unsigned v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_cnt[i] = 0; m_addr[i] = '0; m_valid[i] = 1'b0;
    end
    m_raa  = 0;
    m_last = '0;
  endtask

  // One clock of tracker behaviour, from the rules: pick the hottest row,
  // service the RFM if allowed, then account for the ACT.
  task automatic model_step(input bit a, input logic [AW-1:0] ad, input bit r,
                            output bit ocmd);
    int sel = -1; int hit = -1; int fr = -1; int mn = 0;
    longint unsigned best = 0; longint unsigned hit_pre; longint unsigned mn_pre;
    bit ok;
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && m_cnt[i] > best) begin best = m_cnt[i]; sel = i; end
    ok = r && (m_raa >= TH) && (sel >= 0);
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && m_addr[i] == ad && hit < 0) hit = i;
      if (!m_valid[i] && fr < 0) fr = i;
      if (m_cnt[i] < m_cnt[mn]) mn = i;
    end
    hit_pre = (hit >= 0) ? m_cnt[hit] : 0;
    mn_pre  = m_cnt[mn];
    if (a) m_raa = sat(m_raa);
    if (ok) begin
      m_raa = m_raa - TH;
      m_last = m_addr[sel];
      m_cnt[sel] = 0;
`ifdef RFM_INVALIDATE_EN
      m_valid[sel] = 1'b0; m_addr[sel] = '0;
`endif
    end
    if (a) begin
      if (hit >= 0) begin
        m_cnt[hit] = (ok && hit == sel) ? 1 : sat(hit_pre);
        m_valid[hit] = 1'b1; m_addr[hit] = ad;
      end else if (fr >= 0) begin
        m_cnt[fr] = 1; m_valid[fr] = 1'b1; m_addr[fr] = ad;
      end else begin
        m_cnt[mn] = sat(mn_pre); m_valid[mn] = 1'b1; m_addr[mn] = ad;
      end
    end
    ocmd = ok;
  endtask

  // Drive one clock of stimulus and push the expected response.
  task automatic step(input bit a, input logic [AW-1:0] ad, input bit r, input bit rst);
    exp_t e;
    bit   c;
    rstn = rst; act_cmd = a; act_addr = ad; rfm_cmd = r;
    if (rst) begin
      model_reset();
      c = 1'b0;
    end else begin
      model_step(a, ad, r, c);
    end
    e.due = cyc + 1; e.cmd = c; e.addr = m_last;
    sb.push_back(e);
    @(posedge clk); #1;
    rstn = 1'b0; act_cmd = 1'b0; rfm_cmd = 1'b0;
  endtask

  task automatic acts(input logic [AW-1:0] ad, input int n);
    for (int i = 0; i < n; i++) step(1'b1, ad, 1'b0, 1'b0);
  endtask

  // Monitor: compare each due expectation against the DUT outputs.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      exp_t s;
      s = sb.pop_front();
      vectors++; miscompares++;
      $display("FAIL stale_entry: expectation due at cycle %0d not checked (now %0d)", s.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (nrr_cmd !== e.cmd || nrr_addr !== e.addr) begin
        miscompares++;
        $display("FAIL nrr_out cycle %0d: got cmd=%0b addr=%0d, expected cmd=%0b addr=%0d",
                 cyc, nrr_cmd, nrr_addr, e.cmd, e.addr);
      end
    end
  end

  initial begin
    // Reset, then 5 ACTs to row 7; an RFM with raa=5 must be ignored.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    acts(18'd7, 5);
    step(1'b0, '0, 1'b1, 1'b0);

    // 19 ACTs to row 3, RFM ignored; one more ACT, RFM serviced; RFM again ignored.
    step(1'b0, '0, 1'b0, 1'b1);
    acts(18'd3, 19);
    step(1'b0, '0, 1'b1, 1'b0);
    acts(18'd3, 1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill the table with rows 100..163, then ACT 500 evicts entry 0 (count 2).
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < NE; i++) step(1'b1, 18'(100 + i), 1'b0, 1'b0);
    acts(18'd500, 1);
    step(1'b0, '0, 1'b1, 1'b0);   // hottest is row 500
    step(1'b0, '0, 1'b1, 1'b0);   // back-to-back: tie at 1, lowest index (row 101)

    // Rows 10 x8 and 20 x12, RFM -> 20; 20 ACTs to 30, RFM -> 30.
    step(1'b0, '0, 1'b0, 1'b1);
    acts(18'd10, 8);
    acts(18'd20, 12);
    step(1'b0, '0, 1'b1, 1'b0);
    acts(18'd30, 20);
    step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous RFM + ACT to the max row: row 20 must be left with count 1.
    step(1'b0, '0, 1'b0, 1'b1);
    acts(18'd10, 8);
    acts(18'd20, 12);
    step(1'b1, 18'd20, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b1, 18'(200 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);   // row 10 (count 8)
    for (int i = 0; i < 20; i++) step(1'b1, 18'(300 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);   // row 20 (count 1, lowest index among ties)

    // Reset mid-sequence with an ACT present: everything must clear.
    acts(18'd44, 25);
    step(1'b1, 18'd44, 1'b1, 1'b1);
    acts(18'd5, 19);
    step(1'b0, '0, 1'b1, 1'b0);   // ignored, raa restarted from 0
    step(1'b1, 18'd5, 1'b1, 1'b0); // raa=19 pre-edge: still ignored
    step(1'b0, '0, 1'b1, 1'b0);   // serviced -> row 5

    // Randomized traffic over a pool larger than the table.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      bit a; bit r;
      a = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 2);
      step(a, 18'($urandom_range(0, 79)), r, 1'b0);
    end

    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk); #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
